// File: rtl/sif_bram_reader_if.sv
// Interface bundle for sif_bram_reader: burst control, BRAM read port and dn stream.
// master = the reader, slave = the surrounding logic (requester, BRAM, downstream sink).
interface sif_bram_reader_if #(
  parameter int W  = 16,
  parameter int AW = 10
);
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [W-1:0]  mem_rd_dat;
  logic          dn_vld;
  logic [W-1:0]  dn_dat;
  logic          dn_last;
  logic          dn_rdy;

  modport master (
    input  start, base_addr, len, mem_rd_dat, dn_rdy,
    output busy, done, mem_rd_en, mem_rd_addr, dn_vld, dn_dat, dn_last
  );

  modport slave (
    output start, base_addr, len, mem_rd_dat, dn_rdy,
    input  busy, done, mem_rd_en, mem_rd_addr, dn_vld, dn_dat, dn_last
  );
endinterface

// File: rtl/sif_bram_reader.sv
// Burst reader: streams len words from a fixed-latency BRAM onto a valid/ready port.
// Reads are only issued while in-flight reads plus buffered words leave a free buffer slot.
module sif_bram_reader #(
  parameter int W      = 16,
  parameter int AW     = 10,
  parameter int RD_LAT = 2,
  parameter int BUF_D  = 4
) (
  input logic              clk,
  input logic              rst,
  sif_bram_reader_if.master bus
);
  // state | meaning
  // IDLE  | waiting for start
  // RUN   | issuing BRAM reads under credit control
  // DRAIN | all reads issued, emptying buffer onto dn
  // FIN   | one-cycle done pulse, then back to IDLE
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  localparam int CW = $clog2(BUF_D + 1);
  localparam int PW = (BUF_D > 1) ? $clog2(BUF_D) : 1;

  if (BUF_D < RD_LAT + 1) begin : g_buf_chk
    $error("sif_bram_reader: BUF_D must be at least RD_LAT+1");
  end
  if ((W % 16) != 0) begin : g_w_chk
    $error("sif_bram_reader: W must be a multiple of 16");
  end

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   issued_q, issued_d;
  logic [AW:0]   sent_q, sent_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [W-1:0]  buf_q [BUF_D];
  logic [W-1:0]  buf_d [BUF_D];
  logic [RD_LAT-1:0] vpipe_q;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          rd_en_q;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          dn_vld_q, dn_vld_d;
  logic [W-1:0]  dn_dat_q, dn_dat_d;
  logic          dn_last_q, dn_last_d;
  logic          push, pop, issue;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_D - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    push     = vpipe_q[RD_LAT-1];
    pop      = dn_vld_q & bus.dn_rdy;
    count_d  = count_q + CW'(push) - CW'(pop);
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    buf_d    = buf_q;
    if (push) buf_d[wr_ptr_q] = bus.mem_rd_dat;
    sent_d    = sent_q + (AW+1)'(pop);
    state_d   = state_q;
    len_d     = len_q;
    addr_d    = addr_q;
    issued_d  = issued_q;
    rd_addr_d = rd_addr_q;
    issue     = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        len_d    = bus.len;
        addr_d   = bus.base_addr;
        issued_d = '0;
        sent_d   = '0;
        if (bus.len == '0) state_d = FIN;
        else begin
          state_d = RUN;
          issue   = 1'b1;
        end
      end
      // Credits already used this cycle exclude the word leaving the pipe into the buffer.
      RUN:   issue = (issued_q != len_q) &&
                     ((inflight_q - CW'(push) + count_d) < CW'(BUF_D));
      DRAIN: if (sent_d == len_q) state_d = FIN;
      FIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (issue) begin
      rd_addr_d = addr_d;
      addr_d    = addr_d + AW'(1);
      issued_d  = issued_d + (AW+1)'(1);
    end
    if (state_q == RUN && issued_d == len_q) state_d = DRAIN;
    inflight_d = inflight_q + CW'(issue) - CW'(push);
    busy_d     = (state_d == RUN) || (state_d == DRAIN);
    done_d     = (state_d == FIN);
    dn_vld_d   = (count_d != '0);
    dn_dat_d   = dn_vld_d ? buf_d[rd_ptr_d] : dn_dat_q;
    dn_last_d  = dn_vld_d && (sent_d == len_d - (AW+1)'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      sent_q     <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      buf_q      <= '{default: '0};
      vpipe_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      dn_vld_q   <= 1'b0;
      dn_dat_q   <= '0;
      dn_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      sent_q     <= sent_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      buf_q      <= buf_d;
      vpipe_q[0] <= rd_en_q;
      for (int k = 1; k < RD_LAT; k++) vpipe_q[k] <= vpipe_q[k-1];
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_en_q    <= issue;
      rd_addr_q  <= rd_addr_d;
      dn_vld_q   <= dn_vld_d;
      dn_dat_q   <= dn_dat_d;
      dn_last_q  <= dn_last_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.mem_rd_en   = rd_en_q;
  assign bus.mem_rd_addr = rd_addr_q;
  assign bus.dn_vld      = dn_vld_q;
  assign bus.dn_dat      = dn_dat_q;
  assign bus.dn_last     = dn_last_q;
endmodule
